// File: rtl/video_frame_player.sv
// rtl/video_frame_player.sv - stored-frame replay: video timing, memory prefetch FIFO, 4-bit RGB out
// Fetches one 32-bit word per request into a small FIFO and pops one word per active pixel.
module video_frame_player #(
    parameter int H_ACTIVE = 256,
    parameter int H_TOTAL  = 384,
    parameter int V_ACTIVE = 224,
    parameter int V_TOTAL  = 264,
    parameter int AW       = 24,
    parameter int FIFO_AW  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          enable,
    input  logic [AW-1:0] base_addr,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [31:0]   mem_data,
    input  logic          mem_ok,
    output logic          pxl_hb,
    output logic          pxl_vb,
    output logic [3:0]    red,
    output logic [3:0]    green,
    output logic [3:0]    blue,
    output logic [31:0]   frame_cnt,
    output logic          underrun
);
    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int PIXELS = H_ACTIVE * V_ACTIVE;
    localparam int HW     = $clog2(H_TOTAL);
    localparam int VW     = $clog2(V_TOTAL);
    localparam int FW     = $clog2(PIXELS + 1);
    localparam int CW     = FIFO_AW + 1;

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
    localparam logic [FW-1:0] PIX_C    = FW'(PIXELS);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    logic [HW-1:0]      r_hcnt;
    logic [VW-1:0]      r_vcnt;
    logic               r_hb, r_vb, r_underrun;
    logic [3:0]         r_red, r_green, r_blue;
    logic [31:0]        r_frame_cnt;
    logic [AW-1:0]      r_mem_addr, r_base_q;
    logic               r_mem_rd, r_drop;
    logic [FW-1:0]      r_fetch_cnt;
    logic [31:0]        r_fifo [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic        w_active, w_flush, w_empty, w_pop, w_push, w_issue, w_hwrap, w_vwrap;
    logic [31:0] w_word;

    assign w_active = (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
    assign w_flush  = pxl_cen && (r_hcnt == '0) && (r_vcnt == V_ACT_C);
    assign w_empty  = (r_count == '0);
    assign w_pop    = pxl_cen && w_active && !w_empty;
    assign w_push   = mem_ok && r_mem_rd && !r_drop && !w_flush;
    assign w_issue  = enable && !r_mem_rd && !r_drop && (r_count < DEPTH_C) && (r_fetch_cnt < PIX_C);
    assign w_hwrap  = (r_hcnt == H_LAST_C);
    assign w_vwrap  = (r_vcnt == V_LAST_C);
    assign w_word   = r_fifo[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt      <= '0;
            r_vcnt      <= V_ACT_C;
            r_hb        <= 1'b1;
            r_vb        <= 1'b1;
            r_red       <= '0;
            r_green     <= '0;
            r_blue      <= '0;
            r_frame_cnt <= '0;
            r_underrun  <= 1'b0;
        end else if (pxl_cen) begin
            r_hb <= (r_hcnt >= H_ACT_C);
            r_vb <= (r_vcnt >= V_ACT_C);
            if (w_pop) begin
                r_red   <= w_word[7:4];
                r_green <= w_word[15:12];
                r_blue  <= w_word[23:20];
            end else begin
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
            end
            if (w_active && w_empty) begin
                r_underrun <= 1'b1;
            end
            if (w_hwrap) begin
                r_hcnt <= '0;
                if (w_vwrap) begin
                    r_vcnt      <= '0;
                    r_frame_cnt <= r_frame_cnt + 32'd1;
                end else begin
                    r_vcnt <= r_vcnt + VW'(1);
                end
            end else begin
                r_hcnt <= r_hcnt + HW'(1);
            end
        end
    end

    // A request caught by the flush stays on the bus until mem_ok; the new base waits in r_base_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_base_q    <= '0;
            r_mem_rd    <= 1'b0;
            r_drop      <= 1'b0;
            r_fetch_cnt <= '0;
        end else if (w_flush) begin
            r_fetch_cnt <= '0;
            if (r_mem_rd && !mem_ok) begin
                r_drop   <= 1'b1;
                r_base_q <= base_addr;
            end else begin
                r_mem_addr <= base_addr;
                r_mem_rd   <= w_issue;
            end
        end else if (mem_ok && r_mem_rd) begin
            r_mem_rd <= 1'b0;
            if (r_drop) begin
                r_drop     <= 1'b0;
                r_mem_addr <= r_base_q;
            end else begin
                r_mem_addr  <= r_mem_addr + AW'(1);
                r_fetch_cnt <= r_fetch_cnt + FW'(1);
            end
        end else if (w_issue) begin
            r_mem_rd <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= mem_data;
    end

    assign mem_addr  = r_mem_addr;
    assign mem_rd    = r_mem_rd;
    assign pxl_hb    = r_hb;
    assign pxl_vb    = r_vb;
    assign red       = r_red;
    assign green     = r_green;
    assign blue      = r_blue;
    assign frame_cnt = r_frame_cnt;
    assign underrun  = r_underrun;
endmodule

// File: tb/tb_video_frame_player.sv
// tb/tb_video_frame_player.sv - directed bench for video_frame_player on a 6x5 raster with 4x3 active
module tb_video_frame_player;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pxl_cen = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] base_addr = 24'h100;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [31:0]   mem_data;
    logic          mem_ok;
    logic          pxl_hb, pxl_vb;
    logic [3:0]    red, green, blue;
    logic [31:0]   frame_cnt;
    logic          underrun;

    int   latency = 2;
    bit   manual = 1'b0;
    logic auto_ok = 1'b0;
    logic man_ok = 1'b0;
    int   lat = 0;
    int   div = 0;
    int   rd_rises = 0;
    logic rd_q = 1'b0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          act_idx = 0;
    int          mode = 2;
    logic [23:0] cur_base = 24'h100;
    logic [31:0] first_px = '0;
    int          rd0 = 0;

    assign mem_ok   = auto_ok | man_ok;
    assign mem_data = {8'hFF, 24'(mem_addr * 24'h111)};

    video_frame_player #(
        .H_ACTIVE(4), .H_TOTAL(6), .V_ACTIVE(3), .V_TOTAL(5), .AW(AW), .FIFO_AW(2)
    ) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .enable(enable), .base_addr(base_addr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ok(mem_ok),
        .pxl_hb(pxl_hb), .pxl_vb(pxl_vb), .red(red), .green(green), .blue(blue),
        .frame_cnt(frame_cnt), .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            div     = 0;
            pxl_cen = 1'b0;
        end else begin
            pxl_cen = (div == 3);
            div     = (div + 1) % 4;
        end
    end

    always @(negedge clk) begin
        auto_ok = 1'b0;
        if (rst || manual || !mem_rd) begin
            lat = 0;
        end else begin
            lat = lat + 1;
            if (lat >= latency) begin
                auto_ok = 1'b1;
                lat     = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (mem_rd && !rd_q) rd_rises = rd_rises + 1;
        rd_q = mem_rd;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_rgb(input logic [23:0] a);
        logic [23:0] p;
        p = a * 24'h111;
        return {20'h0, p[7:4], p[15:12], p[23:20]};
    endfunction

    task automatic cen_tick();
        int k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (pxl_cen !== 1'b1 && k < 16);
        check_eq("cen_seen", 32'(pxl_cen), 32'd1);
        #1;
        if (!pxl_hb && !pxl_vb) begin
            if (act_idx == 0) first_px = 32'({red, green, blue});
            if (mode == 0 || (mode == 3 && act_idx < 4))
                check_eq($sformatf("px%0d_base%0h", act_idx, cur_base), 32'({red, green, blue}),
                         exp_rgb(cur_base + 24'(act_idx)));
            else if (mode == 1 || (mode == 3 && act_idx < 8))
                check_eq($sformatf("px%0d_zero", act_idx), 32'({red, green, blue}), 32'd0);
            act_idx++;
        end
    endtask

    task automatic run_cens(input int n);
        for (int i = 0; i < n; i++) cen_tick();
    endtask

    task automatic start_frame(input int m, input logic [23:0] b);
        mode     = m;
        cur_base = b;
        act_idx  = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_hb", 32'(pxl_hb), 32'd1);
        check_eq("rst_vb", 32'(pxl_vb), 32'd1);
        check_eq("rst_rgb", 32'({red, green, blue}), 32'd0);
        check_eq("rst_frame_cnt", frame_cnt, 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);

        enable = 1'b1;
        rst    = 1'b0;
        start_frame(2, 24'h100);
        run_cens(12);
        check_eq("lead_active", 32'(act_idx), 32'd0);
        check_eq("lead_frame_cnt", frame_cnt, 32'd1);

        start_frame(0, 24'h100);
        run_cens(30);
        check_eq("a_active", 32'(act_idx), 32'd12);
        check_eq("a_first_px", first_px, 32'h010);
        check_eq("a_frame_cnt", frame_cnt, 32'd2);
        check_eq("a_underrun", 32'(underrun), 32'd0);

        latency = 40;
        start_frame(3, 24'h100);
        run_cens(16);
        check_eq("b_underrun", 32'(underrun), 32'd1);
        latency = 2;
        run_cens(14);
        check_eq("b_active", 32'(act_idx), 32'd12);
        check_eq("b_frame_cnt", frame_cnt, 32'd3);

        start_frame(0, 24'h100);
        run_cens(16);
        enable    = 1'b0;
        base_addr = 24'h200;
        rd0       = rd_rises;
        run_cens(14);
        check_eq("c_active", 32'(act_idx), 32'd12);
        check_eq("c_underrun_sticky", 32'(underrun), 32'd1);

        start_frame(1, 24'h200);
        run_cens(19);
        check_eq("d_no_rd", 32'(rd_rises - rd0), 32'd0);
        enable = 1'b1;
        run_cens(11);
        check_eq("d_active", 32'(act_idx), 32'd12);
        check_eq("d_frame_cnt", frame_cnt, 32'd5);

        start_frame(0, 24'h200);
        run_cens(30);
        check_eq("e_active", 32'(act_idx), 32'd12);
        check_eq("e_first_px", first_px, 32'h020);

        start_frame(2, 24'h200);
        manual    = 1'b1;
        base_addr = 24'h300;
        run_cens(19);
        check_eq("f_inflight", 32'(mem_rd), 32'd1);
        @(negedge clk);
        man_ok = 1'b1;
        @(negedge clk);
        man_ok = 1'b0;
        manual = 1'b0;
        check_eq("f_drop_done", 32'(mem_rd), 32'd0);
        for (int i = 0; i < 8 && mem_rd !== 1'b1; i++) @(negedge clk);
        check_eq("f_reissue_rd", 32'(mem_rd), 32'd1);
        check_eq("f_reissue_addr", 32'(mem_addr), 32'h300);
        run_cens(11);
        check_eq("f_active", 32'(act_idx), 32'd12);

        start_frame(0, 24'h300);
        run_cens(30);
        check_eq("g_active", 32'(act_idx), 32'd12);
        check_eq("g_first_px", first_px, 32'h030);

        start_frame(2, 24'h300);
        cen_tick();
        for (int i = 0; i < 8 && mem_rd !== 1'b1; i++) @(negedge clk);
        check_eq("h_rd_before_rst", 32'(mem_rd), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("h_rst_hb", 32'(pxl_hb), 32'd1);
        check_eq("h_rst_vb", 32'(pxl_vb), 32'd1);
        check_eq("h_rst_rgb", 32'({red, green, blue}), 32'd0);
        check_eq("h_rst_frame_cnt", frame_cnt, 32'd0);
        check_eq("h_rst_underrun", 32'(underrun), 32'd0);
        check_eq("h_rst_mem_rd", 32'(mem_rd), 32'd0);
        check_eq("h_rst_mem_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        enable = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        man_ok = 1'b1;
        @(negedge clk);
        man_ok = 1'b0;
        #1;
        check_eq("h_stray_addr", 32'(mem_addr), 32'd0);
        check_eq("h_stray_rd", 32'(mem_rd), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
